// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and frame constants for the UART transmitter
package uart_tx_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam int DATA_BITS = 7;
  localparam int FRAME_BITS = 10;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: parallel producer side and serial line of the transmitter
interface uart_tx_core_if import uart_tx_pkg::*; ();
  logic send;
  logic p_s;
  logic [DATA_BITS-1:0] din;
  logic dout;
  logic busy;
  modport master (output send, p_s, din, input dout, busy);
  modport slave (input send, p_s, din, output dout, busy);
endinterface

// File: rtl/uart_tx_datapath.sv
// uart_tx_datapath: frame shift register, parity generation and bit counter
module uart_tx_datapath import uart_tx_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din_i,
  input  logic                 p_s_i,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic                 inc_i,
  input  logic                 rstcnt_i,
  output logic                 dout_o,
  output logic [3:0]           bit_cnt_o
);
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic par;
  assign par = (^din_i) ^ p_s_i;
  always_comb begin
    sr_d = load_i ? {STOP_BIT, par, din_i, START_BIT} : shift_i ? {1'b1, sr_q[FRAME_BITS-1:1]} : sr_q;
    cnt_d = (load_i || rstcnt_i) ? 4'd0 : inc_i ? cnt_q + 4'd1 : cnt_q;
  end
  // ones fill behind the frame so the line returns to idle-high by itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '1;
      cnt_q <= 4'd0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout_o = sr_q[0];
  assign bit_cnt_o = cnt_q;
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: 7-bit + parity UART transmitter, control FSM and baud timing
module uart_tx_core import uart_tx_pkg::*; #(
  parameter int CLKS_PER_BIT = 1
) (
  input logic           clk,
  input logic           rst,
  uart_tx_core_if.slave bus
);
  localparam int BW = $clog2(CLKS_PER_BIT) + 1;
  state_t state_q;
  logic [BW-1:0] baud_q;
  logic busy_q;
  logic [3:0] bit_cnt;
  logic load, shift, last, tc;
  assign tc = baud_q == BW'(CLKS_PER_BIT - 1);
  assign load = state_q == LOAD;
  assign shift = (state_q == SHIFT) && tc;
  assign last = shift && (bit_cnt == 4'(FRAME_BITS - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.send) begin
          state_q <= LOAD;
          busy_q <= 1'b1;
        end
        LOAD: begin
          state_q <= SHIFT;
          baud_q <= '0;
        end
        SHIFT: begin
          baud_q <= tc ? '0 : baud_q + BW'(1);
          if (last) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  uart_tx_datapath u_dp (
    .clk       (clk),
    .rst       (rst),
    .din_i     (bus.din),
    .p_s_i     (bus.p_s),
    .load_i    (load),
    .shift_i   (shift),
    .inc_i     (shift),
    .rstcnt_i  (last),
    .dout_o    (bus.dout),
    .bit_cnt_o (bit_cnt)
  );
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: scoreboard bench for the UART transmitter at 1 and 4 clocks per bit
module tb_uart_tx_core;
  import uart_tx_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_core_if a ();
  uart_tx_core_if b ();
  uart_tx_core #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(a.slave));
  uart_tx_core #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(b.slave));
  int tests = 0;
  int fails = 0;
  logic exp_q[$];

  task automatic push_frame(input logic [6:0] d, input logic p);
    logic [9:0] f;
    f = {STOP_BIT, (^d) ^ p, d, START_BIT};
    for (int i = 0; i < 10; i++) exp_q.push_back(f[i]);
  endtask

  // entered at a negedge; sends one frame on dut1 and ends at the negedge after return to IDLE
  task automatic frame1(input logic [6:0] d, input logic p, input logic hold);
    logic e;
    a.send = 1'b1;
    a.din = d;
    a.p_s = p;
    push_frame(d, p);
    @(negedge clk);
    tests++;
    if (a.busy !== 1'b1 || a.dout !== 1'b1) begin
      fails++;
      $display("FAIL load d=%h: busy=%b dout=%b, required busy=1 dout=1", d, a.busy, a.dout);
    end
    a.send = hold;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        a.din = ~d;
        a.p_s = ~p;
      end
      e = exp_q.pop_front();
      tests++;
      if (a.dout !== e || a.busy !== 1'b1) begin
        fails++;
        $display("FAIL frame d=%h p=%b bit %0d: dout=%b busy=%b, required dout=%b busy=1", d, p, k, a.dout, a.busy, e);
      end
    end
    @(negedge clk);
    tests++;
    if (a.busy !== 1'b0 || a.dout !== 1'b1) begin
      fails++;
      $display("FAIL end d=%h: busy=%b dout=%b, required busy=0 dout=1", d, a.busy, a.dout);
    end
  endtask

  task automatic test_reset;
    a.send = 1'b0; a.din = '0; a.p_s = 1'b0;
    b.send = 1'b0; b.din = '0; b.p_s = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (a.dout !== 1'b1 || a.busy !== 1'b0 || b.dout !== 1'b1 || b.busy !== 1'b0) begin
      fails++;
      $display("FAIL in_reset: dout=%b/%b busy=%b/%b, required dout=1 busy=0", a.dout, b.dout, a.busy, b.busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (a.dout !== 1'b1 || a.busy !== 1'b0 || b.dout !== 1'b1 || b.busy !== 1'b0) begin
        fails++;
        $display("FAIL idle cycle %0d: dout=%b/%b busy=%b/%b, required dout=1 busy=0", i, a.dout, b.dout, a.busy, b.busy);
      end
    end
  endtask

  task automatic test_parity;
    frame1(7'b0000011, 1'b1, 1'b0);
    frame1(7'b0000011, 1'b0, 1'b0);
    frame1(7'b1010101, 1'b0, 1'b0);
    frame1(7'b1010101, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    frame1(7'h3c, 1'b0, 1'b1);
    frame1(7'h41, 1'b1, 1'b1);
    frame1(7'h7f, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    a.send = 1'b1;
    a.din = 7'h00;
    a.p_s = 1'b0;
    @(negedge clk);
    a.send = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (a.dout !== 1'b0 || a.busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_abort bit4: dout=%b busy=%b, required dout=0 busy=1", a.dout, a.busy);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (a.dout !== 1'b1 || a.busy !== 1'b0) begin
      fails++;
      $display("FAIL abort: dout=%b busy=%b, required dout=1 busy=0", a.dout, a.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    frame1(7'h2a, 1'b1, 1'b0);
  endtask

  task automatic test_slow;
    logic e;
    int busy_cnt;
    busy_cnt = 0;
    b.send = 1'b1;
    b.din = 7'h55;
    b.p_s = 1'b0;
    push_frame(7'h55, 1'b0);
    @(negedge clk);
    b.send = 1'b0;
    if (b.busy === 1'b1) busy_cnt++;
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      for (int r = 0; r < 4; r++) begin
        @(negedge clk);
        if (k == 0 && r == 0) b.din = 7'h2a;
        if (b.busy === 1'b1) busy_cnt++;
        tests++;
        if (b.dout !== e) begin
          fails++;
          $display("FAIL slow bit %0d rep %0d: dout=%b, required %b", k, r, b.dout, e);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (b.busy !== 1'b0 || b.dout !== 1'b1) begin
      fails++;
      $display("FAIL slow end: busy=%b dout=%b, required busy=0 dout=1", b.busy, b.dout);
    end
    tests++;
    if (busy_cnt != 41) begin
      fails++;
      $display("FAIL slow busy_len: %0d cycles, required 41", busy_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_parity;
    test_back_to_back;
    test_reset_mid;
    test_slow;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
